risc_multicycle_fsm: RTL and testbench

RISC_MULTICYCLE_FSM -- requirements
Module: risc_multicycle_fsm

---
 rtl/risc_multicycle_fsm.sv | 218 +++++++++++++++++++++
 tb/tb_risc_multicycle_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/risc_multicycle_fsm.sv
// risc_multicycle_fsm
//   Main control FSM of a multicycle RISC-V style core (lw, sw, R-type,
//   I-type ALU, beq, jal). The state is a register; every control output is
//   combinational from the current state and the instruction fields, so the
//   datapath sees the controls in the same cycle the state is entered.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset (forces FETCH, silences enables)
//   op           opcode, instruction bits [6:0]
//   funct3       instruction bits [14:12]
//   funct7b5     instruction bit 30
//   zero         ALU zero flag
//   mem_ready    memory accepts/completes the current access this cycle
//   mem_req      memory access requested this cycle
//   adr_src      memory address: 0 = PC, 1 = ALU result register
//   ir_write, pc_write, reg_write, mem_write   write enables
//   result_src   00 ALUOut, 01 Data, 10 ALUResult
//   alu_src_a    00 PC, 01 OldPC, 10 rs1
//   alu_src_b    00 rs2, 01 ImmExt, 10 constant 4
//   alu_control  000 add, 001 sub, 010 and, 011 or, 101 slt
//   imm_src      00 I, 01 S, 10 B, 11 J
//   instr_done   pulse on the last cycle of each instruction
//   illegal_op   pulse in DECODE for an unsupported opcode
//   state        current state code, for debug
module risc_multicycle_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic       mem_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] imm_src,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t cur, nxt;
   logic [2:0] alu_funct;

   assign state = cur;

   always_ff @(posedge clk) begin
      if (rst) cur <= S_FETCH;
      else     cur <= nxt;
   end

   // Subtract only for R-type (op[5]=1) with funct7b5 set; addi with bit 30
   // set is still an add because that bit belongs to the immediate.
   always_comb begin
      alu_funct = ALU_ADD;
      case (funct3)
         3'b000:  alu_funct = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_funct = ALU_SLT;
         3'b110:  alu_funct = ALU_OR;
         3'b111:  alu_funct = ALU_AND;
         default: alu_funct = ALU_ADD;
      endcase
   end

   always_comb begin
      case (op)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   always_comb begin
      nxt         = S_FETCH;
      mem_req     = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = ALU_ADD;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;

      case (cur)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            nxt        = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_R:         nxt = S_EXECR;
               OP_I:         nxt = S_EXECI;
               OP_BEQ:       nxt = S_BEQ;
               OP_JAL:       nxt = S_JAL;
               default: begin
                  nxt        = S_FETCH;
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            nxt       = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            nxt     = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            nxt        = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req    = 1'b1;
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            instr_done = mem_ready;
            nxt        = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b00;
            alu_control = alu_funct;
            nxt         = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = alu_funct;
            nxt         = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            nxt        = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b00;
            alu_control = ALU_SUB;
            pc_write    = zero;
            instr_done  = 1'b1;
            nxt         = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            nxt       = S_ALUWB;
         end
         default: nxt = S_FETCH;
      endcase

      // Reset wins over whatever the current state would request.
      if (rst) begin
         mem_req    = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         reg_write  = 1'b0;
         mem_write  = 1'b0;
         instr_done = 1'b0;
         illegal_op = 1'b0;
      end
   end

endmodule

// File: tb/tb_risc_multicycle_fsm.sv
// tb_risc_multicycle_fsm
//   Scoreboard bench for risc_multicycle_fsm. The driver plans each
//   instruction as a timeline (fetch stalls, memory stalls), pushes the
//   expected per-instruction summary and drives the inputs; the monitor
//   accumulates what the DUT shows each cycle and compares on instr_done.
module tb_risc_multicycle_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, zero, mem_ready;
   logic       mem_req, adr_src, ir_write, pc_write, reg_write, mem_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_control;
   logic       instr_done, illegal_op;
   logic [3:0] state;

   always #5 clk = ~clk;

   risc_multicycle_fsm dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .mem_write(mem_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
      .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
   );

   typedef struct {
      logic [63:0] trace;
      int          ir_n, pc_n, reg_n, memw_n, req_n, ill_n;
      logic [2:0]  alu;
      logic [1:0]  imm;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;

   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic [63:0] a_trace = 64'hF;
   int          a_ir = 0, a_pc = 0, a_reg = 0, a_memw = 0, a_req = 0, a_ill = 0;
   logic [2:0]  a_alu = 3'b111;
   logic [1:0]  a_imm = 2'b00;

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         exp_t e;
         a_trace = (a_trace << 4) | 64'(state);
         a_ir   += int'(ir_write);
         a_pc   += int'(pc_write);
         a_reg  += int'(reg_write);
         a_memw += int'(mem_write);
         a_req  += int'(mem_req);
         a_ill  += int'(illegal_op);
         if (state == 4'd6 || state == 4'd7 || state == 4'd9) a_alu = alu_control;
         if (state == 4'd1) a_imm = imm_src;
         if (instr_done) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("state_trace", a_trace, e.trace);
               check("ir_write_cnt", 64'(a_ir), 64'(e.ir_n));
               check("pc_write_cnt", 64'(a_pc), 64'(e.pc_n));
               check("reg_write_cnt", 64'(a_reg), 64'(e.reg_n));
               check("mem_write_cnt", 64'(a_memw), 64'(e.memw_n));
               check("mem_req_cnt", 64'(a_req), 64'(e.req_n));
               check("illegal_cnt", 64'(a_ill), 64'(e.ill_n));
               check("alu_control", 64'(a_alu), 64'(e.alu));
               check("imm_src", 64'(a_imm), 64'(e.imm));
            end
            a_trace = 64'hF;
            a_ir = 0; a_pc = 0; a_reg = 0; a_memw = 0; a_req = 0; a_ill = 0;
            a_alu = 3'b111;
            a_imm = 2'b00;
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [2:0] model_alu(input bit rtype, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return (rtype && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [63:0] push_st(input logic [63:0] t, input int s);
      return (t << 4) | 64'(s);
   endfunction

   // fw = fetch stall cycles, mw = memory stall cycles.
   task automatic run_instr(input int kind, input int fw, input int mw,
                            input logic [2:0] f3, input logic f7, input logic z,
                            input logic [6:0] ill_op);
      exp_t       e;
      logic [6:0] o;
      int         len, mem_first, mem_last;
      case (kind)
         K_LW:    o = 7'b0000011;
         K_SW:    o = 7'b0100011;
         K_R:     o = 7'b0110011;
         K_I:     o = 7'b0010011;
         K_BEQ:   o = 7'b1100011;
         K_JAL:   o = 7'b1101111;
         default: o = ill_op;
      endcase

      e.trace = 64'hF;
      for (int i = 0; i <= fw; i++) e.trace = push_st(e.trace, 0);
      e.trace = push_st(e.trace, 1);
      len = fw + 2;
      mem_first = -1;
      mem_last  = -1;
      case (kind)
         K_LW: begin
            e.trace = push_st(e.trace, 2);
            for (int i = 0; i <= mw; i++) e.trace = push_st(e.trace, 3);
            e.trace = push_st(e.trace, 4);
            mem_first = fw + 3; mem_last = fw + 3 + mw;
            len += mw + 3;
         end
         K_SW: begin
            e.trace = push_st(e.trace, 2);
            for (int i = 0; i <= mw; i++) e.trace = push_st(e.trace, 5);
            mem_first = fw + 3; mem_last = fw + 3 + mw;
            len += mw + 2;
         end
         K_R:   begin e.trace = push_st(push_st(e.trace, 6), 8); len += 2; end
         K_I:   begin e.trace = push_st(push_st(e.trace, 7), 8); len += 2; end
         K_BEQ: begin e.trace = push_st(e.trace, 9); len += 1; end
         K_JAL: begin e.trace = push_st(push_st(e.trace, 10), 8); len += 2; end
         default: ;
      endcase

      e.ir_n   = 1;
      e.pc_n   = 1 + ((kind == K_BEQ && z) ? 1 : 0) + ((kind == K_JAL) ? 1 : 0);
      e.reg_n  = (kind == K_LW || kind == K_R || kind == K_I || kind == K_JAL) ? 1 : 0;
      e.memw_n = (kind == K_SW) ? mw + 1 : 0;
      e.req_n  = fw + 1 + ((kind == K_LW || kind == K_SW) ? mw + 1 : 0);
      e.ill_n  = (kind == K_ILL) ? 1 : 0;
      e.alu    = (kind == K_R)   ? model_alu(1'b1, f3, f7) :
                 (kind == K_I)   ? model_alu(1'b0, f3, f7) :
                 (kind == K_BEQ) ? 3'b001 : 3'b111;
      e.imm    = (kind == K_SW) ? 2'b01 : (kind == K_BEQ) ? 2'b10 :
                 (kind == K_JAL) ? 2'b11 : 2'b00;
      sb.push_back(e);

      for (int c = 0; c < len; c++) begin
         op = o; funct3 = f3; funct7b5 = f7; zero = z;
         if (c <= fw)                                mem_ready = (c == fw);
         else if (c >= mem_first && c <= mem_last)   mem_ready = (c == mem_last);
         else                                        mem_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
   endtask

   function automatic bit is_legal(input logic [6:0] o);
      return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
             o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [6:0] rop;
      rst = 1'b1; op = 7'b0000011; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_enables", 64'({ir_write, pc_write, reg_write, mem_write}), 64'd0);
      check("rst_done_ill", 64'({instr_done, illegal_op}), 64'd0);
      check("rst_state", 64'(state), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;

      run_instr(K_LW,  0, 0, 3'b000, 1'b0, 1'b0, 7'h00);
      run_instr(K_R,   0, 0, 3'b000, 1'b1, 1'b0, 7'h00);
      run_instr(K_I,   0, 0, 3'b000, 1'b1, 1'b0, 7'h00);
      run_instr(K_BEQ, 0, 0, 3'b000, 1'b0, 1'b1, 7'h00);
      run_instr(K_BEQ, 0, 0, 3'b000, 1'b0, 1'b0, 7'h00);
      run_instr(K_R,   3, 0, 3'b110, 1'b0, 1'b0, 7'h00);
      run_instr(K_ILL, 0, 0, 3'b000, 1'b0, 1'b0, 7'h7F);
      run_instr(K_SW,  1, 2, 3'b010, 1'b0, 1'b0, 7'h00);
      run_instr(K_JAL, 0, 0, 3'b000, 1'b0, 1'b0, 7'h00);

      for (int n = 0; n < 40; n++) begin
         do rop = 7'($urandom); while (is_legal(rop));
         run_instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 3'($urandom), 1'($urandom),
                   1'($urandom), rop);
      end

      mon_en = 1'b0;
      check("sb_drained", 64'(sb.size()), 64'd0);

      // Reset arriving mid-store while memory is stalled.
      op = 7'b0100011; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
      mem_ready = 1'b1; @(posedge clk); #1;
      mem_ready = 1'b0; @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mw_state", 64'(state), 64'd5);
      check("rst_mw_mem_write", 64'(mem_write), 64'd0);
      check("rst_mw_mem_req", 64'(mem_req), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_state", 64'(state), 64'd0);
      check("post_rst_mem_req", 64'(mem_req), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
